// File: rtl/pwm_ramp_controller.sv
// Ramps the PWM duty-cycle value toward a commanded target in fixed steps at a programmable rate.
// Optional breathing mode (continuous up/down ramp) is enabled by defining PWM_RAMP_AUTOREVERSE_EN.
module pwm_ramp_controller #(
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DUTY_W-1:0]     target_duty,
  input  logic [DUTY_W-1:0]     step_size,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DUTY_W-1:0]     duty_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   cnt_q, cnt_d;
  logic [PRESCALE_W-1:0]   pre_q, pre_d;
  logic [DUTY_W-1:0]       tgt_q, tgt_d;
  logic [DUTY_W-1:0]       step_q, step_d;
  logic [DUTY_W-1:0]       duty_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    rev_hit;
`ifdef PWM_RAMP_AUTOREVERSE_EN
  logic [DUTY_W-1:0]       org_q, org_d;
`endif

  logic                    retarget;
  logic                    going_up;
  logic [DUTY_W-1:0]       tgt_eff;
  logic [DUTY_W-1:0]       step_eff;
  logic [DUTY_W-1:0]       step_nz;
  logic [DUTY_W-1:0]       diff;
  logic [DUTY_W-1:0]       inc;
  logic [DUTY_W-1:0]       stepped;

  // Next-state, datapath and registered-output values
  always_comb begin
    retarget = (state_q == S_RAMP) && start && !abort;
    tgt_eff  = retarget ? target_duty : tgt_q;
    step_eff = retarget ? step_size : step_q;
    step_nz  = (step_eff == '0) ? DUTY_W'(1) : step_eff;
    going_up = (tgt_eff > duty_out);
    diff     = going_up ? (tgt_eff - duty_out) : (duty_out - tgt_eff);
    // Clamp to the remaining distance so the step can neither overshoot nor wrap
    inc      = (step_nz < diff) ? step_nz : diff;
    stepped  = going_up ? (duty_out + inc) : (duty_out - inc);

    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    duty_d   = duty_out;
    rev_hit  = 1'b0;
`ifdef PWM_RAMP_AUTOREVERSE_EN
    org_d    = org_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          tgt_d  = target_duty;
          step_d = step_size;
          pre_d  = prescale;
          cnt_d  = prescale;
`ifdef PWM_RAMP_AUTOREVERSE_EN
          org_d  = duty_out;
`endif
          state_d = (target_duty == duty_out) ? S_DONE : S_RAMP;
        end
      end
      S_RAMP: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (retarget) begin
            tgt_d  = target_duty;
            step_d = step_size;
          end
          if (retarget && (target_duty == duty_out)) begin
            state_d = S_DONE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PRESCALE_W'(1);
          end else begin
            cnt_d  = pre_q;
            duty_d = stepped;
            if (stepped == tgt_eff) begin
`ifdef PWM_RAMP_AUTOREVERSE_EN
              // Swap endpoints and keep breathing unless the ramp has zero span
              if (org_q != tgt_eff) begin
                tgt_d   = org_q;
                org_d   = tgt_eff;
                rev_hit = 1'b1;
              end else begin
                state_d = S_DONE;
              end
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort) begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) || rev_hit;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pre_q    <= '0;
      tgt_q    <= '0;
      step_q   <= '0;
      duty_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PWM_RAMP_AUTOREVERSE_EN
      org_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      duty_out <= duty_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef PWM_RAMP_AUTOREVERSE_EN
      org_q    <= org_d;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed, table-driven bench for pwm_ramp_controller plus hand-written retarget and breathing sequences.
module tb_pwm_ramp_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  target_duty;
  logic [7:0]  step_size;
  logic [15:0] prescale;
  logic [7:0]  duty_out;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  pwm_ramp_controller #(.DUTY_W(8), .PRESCALE_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .target_duty (target_duty),
    .step_size   (step_size),
    .prescale    (prescale),
    .duty_out    (duty_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  tgt;
    logic [7:0]  step;
    logic [15:0] pre;
    logic [7:0]  e_duty;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic a, logic [7:0] t, logic [7:0] st,
                              logic [15:0] p, logic [7:0] ed, logic eb, logic edn);
    vec_t v;
    v.rst = r; v.start = s; v.abort = a; v.tgt = t; v.step = st; v.pre = p;
    v.e_duty = ed; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge, clock once, then sample 1 time unit past the edge
  task automatic drive(input logic r, input logic s, input logic a, input logic [7:0] t,
                       input logic [7:0] st, input logic [15:0] p);
    rst = r; start = s; abort = a; target_duty = t; step_size = st; prescale = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFFFF);
  endtask

  int done_cnt;
  int es_found;
  logic [7:0] ar_duty [8];
  logic       ar_done [8];

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    target_duty = '0; step_size = '0; prescale = '0;

    // Basic ramp 0 -> 0x10, step 4, prescale 2 (inputs wiggle between starts)
    vecs.push_back(mk(1,0,0, 8'h00,8'h00,16'd0, 8'h00,0,0));
    vecs.push_back(mk(0,1,0, 8'h10,8'h04,16'd2, 8'h00,1,0));
    vecs.push_back(mk(0,0,0, 8'hFF,8'hFF,16'd0, 8'h00,1,0));
    vecs.push_back(mk(0,0,0, 8'hFF,8'hFF,16'd0, 8'h00,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd9, 8'h04,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h04,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h04,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h08,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h08,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h08,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h0C,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h0C,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h0C,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h10,1,1));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h10,0,0));
    // Jump to 0xFE in one clamped step, then ramp down to 0 without underflow
    vecs.push_back(mk(0,1,0, 8'hFE,8'hFF,16'd0, 8'h10,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'hFE,1,1));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'hFE,0,0));
    vecs.push_back(mk(0,1,0, 8'h00,8'h40,16'd0, 8'hFE,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'hBE,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h7E,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h3E,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h00,1,1));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h00,0,0));
    // Step size 0 acts as 1
    vecs.push_back(mk(0,1,0, 8'h05,8'h00,16'd0, 8'h00,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h01,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h02,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h03,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h04,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h05,1,1));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h05,0,0));
    // Start with target equal to current duty goes straight to DONE
    vecs.push_back(mk(0,1,0, 8'h05,8'h01,16'd7, 8'h05,1,1));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h05,0,0));
    // Start+abort mid-ramp: abort wins, duty frozen, then reset clears it
    vecs.push_back(mk(0,1,0, 8'h20,8'h01,16'd0, 8'h05,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h06,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h07,1,0));
    vecs.push_back(mk(0,1,1, 8'h00,8'h01,16'd0, 8'h07,0,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h07,0,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h07,0,0));
    vecs.push_back(mk(1,0,0, 8'h00,8'h00,16'd0, 8'h00,0,0));
    // Reset in the middle of a ramp
    vecs.push_back(mk(0,1,0, 8'h30,8'h10,16'd0, 8'h00,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h10,1,0));
    vecs.push_back(mk(1,0,0, 8'h00,8'h00,16'd0, 8'h00,0,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h00,0,0));
    // Abort in DONE, and start in DONE ignored
    vecs.push_back(mk(0,1,0, 8'h03,8'h03,16'd0, 8'h00,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h03,1,1));
    vecs.push_back(mk(0,0,1, 8'h00,8'h00,16'd0, 8'h03,0,0));
    vecs.push_back(mk(0,1,0, 8'h06,8'h06,16'd0, 8'h03,1,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h06,1,1));
    vecs.push_back(mk(0,1,0, 8'h40,8'h01,16'd0, 8'h06,0,0));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00,16'd0, 8'h06,0,0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].tgt, vecs[i].step, vecs[i].pre);
      chk($sformatf("v%0d duty", i), 32'(duty_out), 32'(vecs[i].e_duty));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
    end

    // Retarget at 0x20 toward 0x10: the running interval continues unchanged
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h80, 8'h08, 16'd3);
    done_cnt = 0;
    es_found = 0;
    for (int c = 0; c < 200; c++) begin
      if (duty_out == 8'h20) begin
        es_found = 1;
        break;
      end
      if (done) done_cnt++;
      idle_cycle();
    end
    chk("retarget reach 0x20", 32'(es_found), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h08, 16'd0);
    chk("retarget busy", 32'(busy), 32'd1);
    idle_cycle();
    idle_cycle();
    chk("retarget hold", 32'(duty_out), 32'h20);
    idle_cycle();
    chk("retarget first step", 32'(duty_out), 32'h18);
    for (int c = 0; c < 4; c++) begin
      if (done) done_cnt++;
      idle_cycle();
    end
    chk("retarget final duty", 32'(duty_out), 32'h10);
    chk("retarget done", 32'(done), 32'd1);
    if (done) done_cnt++;
    idle_cycle();
    chk("retarget busy end", 32'(busy), 32'd0);
    chk("retarget done count", 32'(done_cnt), 32'd1);

`ifdef PWM_RAMP_AUTOREVERSE_EN
    // Breathing between 0 and 8; abort exits and holds the duty
    ar_duty = '{8'h00, 8'h04, 8'h08, 8'h04, 8'h00, 8'h04, 8'h08, 8'h04};
    ar_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h08, 8'h04, 16'd0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) idle_cycle();
      chk($sformatf("rev%0d duty", k), 32'(duty_out), 32'(ar_duty[k]));
      chk($sformatf("rev%0d done", k), 32'(done), 32'(ar_done[k]));
      chk($sformatf("rev%0d busy", k), 32'(busy), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 16'd0);
    chk("rev abort duty", 32'(duty_out), 32'h04);
    chk("rev abort busy", 32'(busy), 32'd0);
    chk("rev abort done", 32'(done), 32'd0);
    idle_cycle();
    chk("rev idle duty", 32'(duty_out), 32'h04);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
